muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Execute-stage iterative RV64M multiply/divide unit. Consumes the decoder's 4-bit mulOp and the
//  rs1/rs2 operand values for instructions flagged rvm, and returns a 64-bit writeback result.
//  Radix-2 shift-add multiply and restoring divide, one bit per cycle. Valid/ready on both sides.
// PARAMETERS
//  XLEN  64  operand/result width (only 64 supported)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  in_valid   in   1   op request valid
//  in_ready   out  1   unit idle and can accept (high only in IDLE)
//  mul_op     in   4   0000 mul, 0100 div, 0101 divu, 0110 rem, 0111 remu,
//                      1000 mulw, 1100 divw, 1101 divuw, 1110 remw, 1111 remuw
//  src_a      in   64  rs1 value (dividend / multiplicand)
//  src_b      in   64  rs2 value (divisor / multiplier)
//  flush      in   1   abort any in-flight op (pipeline redirect/trap)
//  out_valid  out  1   result valid; held until out_ready
//  out_ready  in   1   consumer accepts result
//  result     out  64  final result, sign-extended from bit 31 for W ops
// BEHAVIOUR
//  Single clock; synchronous active-high reset. On reset: state=IDLE, in_ready=1, out_valid=0,
//  result=0, counter=0, internal registers=0. Reset mid-operation discards the op silently.
//  Accept: in_valid && in_ready at edge t latches op, operands, and signs.
//  Unlisted mul_op codes execute as mul.
//  W ops: operands are the low 32 bits; signed W ops sign-extend them, unsigned W ops zero-extend.
//  Iteration count N=32 for W ops and N=64 otherwise.
//  States:
//   IDLE -> MUL or DIV on accept.
//   IDLE -> DONE on accept when a divide special case applies.
//   MUL/DIV -> FIX once the counter reaches N-1 (N cycles).
//   FIX -> DONE after 1 cycle.
//   DONE -> IDLE when out_ready is high.
//  Latency: out_valid first high in cycle t+N+2 (t+66 for 64-bit ops, t+34 for W ops).
//  Special cases: out_valid in cycle t+1.
//  MUL: the product is computed on the raw operand bits; the result is the low XLEN bits
//   (low 32 bits for mulw), so signedness is irrelevant.
//  DIV: signed ops divide |a| by |b| in unsigned form.
//   Quotient is negated iff sign(a)!=sign(b). Remainder takes the sign of a. Negation happens in FIX.
//  Special cases, resolved at accept and with no iteration:
//   divide by zero: quotient = all ones (-1 at op width); remainder = a.
//   signed overflow (a = most-negative, b = -1): quotient = a; remainder = 0.
//   Op width is 64 bits, or 32 bits for W ops; W results are sign-extended.
//  result and out_valid are stable while out_valid && !out_ready (backpressure).
//  An accept may occur in the cycle after the DONE->IDLE handshake, never in the same cycle.
//  flush: in any state next state=IDLE and out_valid=0; a pending DONE result is dropped.
//   flush overrides in_valid in the same cycle: nothing is accepted.
//  reset has priority over flush.
// TESTING
//  mul a=3, b=-5 (0xFFFF_FFFF_FFFF_FFFB) -> result 0xFFFF_FFFF_FFFF_FFF1 at t+66.
//  div a=-7, b=2 -> -3 (0xFFFF_FFFF_FFFF_FFFD); rem same operands -> -1 (all ones).
//  divu a=42, b=0 -> 0xFFFF_FFFF_FFFF_FFFF at t+1; remu a=42, b=0 -> 42.
//  div a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000 at t+1.
//   rem with the same operands -> 0.
//  mulw a=0x7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE at t+34.
//   divuw a=0xFFFF_FFFF_0000_0010, b=4 -> 4.
//  Hold out_ready=0 for 5 cycles: result and out_valid are stable and in_ready=0.
//   flush at cycle t+10 of a div: IDLE next cycle, no out_valid.
//   reset mid-op behaves the same, with all outputs at reset values.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on request and result.
module muldiv_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      mul_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_t;

    state_t          state;
    logic [5:0]      cnt_q;
    logic [XLEN-1:0] acc_q;    // product accumulator / partial remainder
    logic [XLEN-1:0] opa_q;    // multiplicand / dividend shifting into quotient
    logic [XLEN-1:0] opb_q;    // multiplier / divisor
    logic            w_q, div_q, rem_sel_q, neg_quo_q, neg_rem_q;

    // Request decode
    logic            op_div, op_w, op_rem, op_sgn;
    logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, a_sext, min_val, spec_res;
    logic            neg_a, neg_b, div_zero, div_ovf;

    always_comb begin
        op_div = mul_op[2];
        op_w   = mul_op[3] && (mul_op[2] || mul_op[1:0] == 2'b00);
        op_rem = op_div && mul_op[1];
        op_sgn = op_div && !mul_op[0];
        if (op_w) begin
            ext_a = op_sgn ? {{(XLEN-32){src_a[31]}}, src_a[31:0]} : {{(XLEN-32){1'b0}}, src_a[31:0]};
            ext_b = op_sgn ? {{(XLEN-32){src_b[31]}}, src_b[31:0]} : {{(XLEN-32){1'b0}}, src_b[31:0]};
        end else begin
            ext_a = src_a;
            ext_b = src_b;
        end
        neg_a    = op_sgn && ext_a[XLEN-1];
        neg_b    = op_sgn && ext_b[XLEN-1];
        mag_a    = neg_a ? -ext_a : ext_a;
        mag_b    = neg_b ? -ext_b : ext_b;
        a_sext   = op_w ? {{(XLEN-32){src_a[31]}}, src_a[31:0]} : src_a;
        min_val  = op_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = op_div && (ext_b == '0);
        div_ovf  = op_div && op_sgn && (ext_a == min_val) && (ext_b == '1);
        if (div_zero) spec_res = op_rem ? a_sext : '1;
        else          spec_res = op_rem ? '0 : a_sext;
    end

    // Per-cycle iteration step
    logic [XLEN-1:0] mul_sum, div_rem, fix_val, fix_res;
    logic [XLEN:0]   div_shift, div_trial;
    logic            div_ge, last;

    always_comb begin
        mul_sum   = acc_q + (opb_q[0] ? opa_q : '0);
        div_shift = {acc_q, (w_q ? opa_q[31] : opa_q[XLEN-1])};
        div_trial = div_shift - {1'b0, opb_q};
        div_ge    = !div_trial[XLEN];
        div_rem   = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
        last      = (cnt_q == (w_q ? 6'd31 : 6'd63));
        if (!div_q)         fix_val = acc_q;
        else if (rem_sel_q) fix_val = neg_rem_q ? -acc_q : acc_q;
        else                fix_val = neg_quo_q ? -opa_q : opa_q;
        fix_res = w_q ? {{(XLEN-32){fix_val[31]}}, fix_val[31:0]} : fix_val;
    end

    assign in_ready = (state == StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            result    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            w_q       <= 1'b0;
            div_q     <= 1'b0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (flush) begin
            state     <= StIdle;
            out_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        w_q       <= op_w;
                        div_q     <= op_div;
                        rem_sel_q <= op_rem;
                        neg_quo_q <= neg_a ^ neg_b;
                        neg_rem_q <= neg_a;
                        cnt_q     <= '0;
                        acc_q     <= '0;
                        opa_q     <= mag_a;
                        opb_q     <= mag_b;
                        if (div_zero || div_ovf) begin
                            result    <= spec_res;
                            out_valid <= 1'b1;
                            state     <= StDone;
                        end else begin
                            state <= op_div ? StDiv : StMul;
                        end
                    end
                end
                StMul: begin
                    acc_q <= mul_sum;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q + 6'd1;
                    if (last) state <= StFix;
                end
                StDiv: begin
                    acc_q <= div_rem;
                    opa_q <= {opa_q[XLEN-2:0], div_ge};
                    cnt_q <= cnt_q + 6'd1;
                    if (last) state <= StFix;
                end
                StFix: begin
                    result    <= fix_res;
                    out_valid <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit plus backpressure, flush and reset sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [3:0]  mul_op;
    logic [63:0] src_a, src_b, result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mul_op   (mul_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        mul_op   = op;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Returns cycles after the accept edge until out_valid is seen (capped at 200).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_ovalid_clr"}, {63'b0, out_valid}, 64'd0);
        check({name, "_iready"}, {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{"mul_3_m5",     4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 66};
        vecs[1]  = '{"div_m7_2",     4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        vecs[2]  = '{"rem_m7_2",     4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        vecs[3]  = '{"divu_42_0",    4'b0101, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[4]  = '{"remu_42_0",    4'b0111, 64'd42, 64'd0, 64'd42, 1};
        vecs[5]  = '{"div_ovf",      4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 1};
        vecs[6]  = '{"rem_ovf",      4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        vecs[7]  = '{"mulw",         4'b1000, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34};
        vecs[8]  = '{"divuw",        4'b1101, 64'hFFFF_FFFF_0000_0010, 64'd4, 64'd4, 34};
        vecs[9]  = '{"divu_100_7",   4'b0101, 64'd100, 64'd7, 64'd14, 66};
        vecs[10] = '{"remu_100_7",   4'b0111, 64'd100, 64'd7, 64'd2, 66};
        vecs[11] = '{"divw_m100_7",  4'b1100, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 34};
        vecs[12] = '{"remw_m100_7",  4'b1110, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 34};
        vecs[13] = '{"mul_wide",     4'b0000, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 66};
        vecs[14] = '{"unlisted_mul", 4'b0001, 64'd6, 64'd7, 64'd42, 66};
        vecs[15] = '{"divw_zero",    4'b1100, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[16] = '{"remw_ovf",     4'b1110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
        vecs[17] = '{"divw_ovf",     4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[18] = '{"div_m7_m2",    4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 66};

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        mul_op = 4'b0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_iready", {63'b0, in_ready}, 64'd1);
        check("rst_ovalid", {63'b0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);

        for (int i = 0; i < 19; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(lat);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, "_res"}, result, vecs[i].res);
            release_result(vecs[i].name);
        end

        // Backpressure: result held for 5 cycles with out_ready low
        issue(4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'd66);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_ovalid", {63'b0, out_valid}, 64'd1);
            check("bp_result", result, 64'hFFFF_FFFF_FFFF_FFF1);
            check("bp_iready", {63'b0, in_ready}, 64'd0);
        end
        release_result("bp");

        // Flush at cycle t+10 of a divide
        issue(4'b0101, 64'd100, 64'd7);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_iready", {63'b0, in_ready}, 64'd1);
        check("flush_ovalid", {63'b0, out_valid}, 64'd0);

        // Flush with a concurrent request: nothing may be accepted
        @(negedge clk);
        mul_op = 4'b0101; src_a = 64'd42; src_b = 64'd0;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            if (out_valid || !in_ready) seen++;
            @(posedge clk);
            #1;
        end
        check("flush_quiet", 64'(seen), 64'd0);

        // Reset mid-op: outputs return to reset values
        issue(4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_iready", {63'b0, in_ready}, 64'd1);
        check("midrst_ovalid", {63'b0, out_valid}, 64'd0);
        check("midrst_result", result, 64'd0);
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("midrst_quiet", 64'(seen), 64'd0);

        // Unit still operational afterwards
        issue(4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_valid(lat);
        check("post_lat", 64'(lat), 64'd66);
        check("post_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
        release_result("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
